// File: rtl/cpu_pkg.sv
// Shared types and constants for the simple 8-bit, 4-register CPU core.
// Holds the opcode and FSM state encodings and the instruction field positions.
package cpu_pkg;

  localparam int DATA_W    = 8;
  localparam int PC_W      = 4;
  localparam int REG_SEL_W = 2;

  // Instruction field bit positions.
  localparam int OP_HI  = 7;
  localparam int OP_LO  = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 4;
  localparam int RS_HI  = 3;
  localparam int RS_LO  = 2;
  localparam int RT_HI  = 1;
  localparam int RT_LO  = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 5;
  localparam int TGT_LO = 2;
  localparam int BRS_HI = 1;
  localparam int BRS_LO = 0;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_NOP   = 2'b01,
    OP_LI    = 2'b10,
    OP_BNER0 = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

endpackage

// File: rtl/register_file.sv
// 4x8 register file: two combinational operand read ports, one debug read port,
// one synchronous write port, cleared by synchronous reset.
module register_file
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_SEL_W-1:0] ra_sel,
  input  logic [REG_SEL_W-1:0] rb_sel,
  input  logic [REG_SEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  output logic [DATA_W-1:0]    dbg_data,
  input  logic                 we,
  input  logic [REG_SEL_W-1:0] wr_sel,
  input  logic [DATA_W-1:0]    wr_data
);

  logic [DATA_W-1:0] regs [4];

  // NOTE: only four registers, so they are plain flops and reset is cheap; a
  // large RAM-style array would be left unreset so it can map to memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_sel] <= wr_data;
    end
  end

  // Reads return the pre-write contents, so rd == rs/rt sees old operands.
  assign ra_data  = regs[ra_sel];
  assign rb_data  = regs[rb_sel];
  assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/simple_cpu_core.sv
// Two-cycle (FETCH/EXEC) CPU core with ADD, NOP, LI and BNER0; program storage
// lives outside the core and is read combinationally through pc/instruction.
module simple_cpu_core
  import cpu_pkg::*;
#(
  parameter int HALT_ON_SELF_LOOP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  output logic [PC_W-1:0]      pc,
  input  logic [DATA_W-1:0]    instruction,
  output logic                 retire,
  output logic [DATA_W-1:0]    retire_count,
  output logic                 halted,
  input  logic [REG_SEL_W-1:0] dbg_sel,
  output logic [DATA_W-1:0]    dbg_data
);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q;
  logic [DATA_W-1:0]      ir_q;
  logic [DATA_W-1:0]      count_q;

  opcode_e                op;
  logic [REG_SEL_W-1:0]   ra_sel, rb_sel;
  logic [DATA_W-1:0]      ra_data, rb_data;
  logic [PC_W-1:0]        target;
  logic                   exec;
  logic                   branch_taken;
  logic                   self_loop;
  logic [PC_W-1:0]        pc_next;
  logic                   we;
  logic [DATA_W-1:0]      wr_data;

  assign op     = opcode_e'(ir_q[OP_HI:OP_LO]);
  assign target = ir_q[TGT_HI:TGT_LO];
  assign exec   = (state_q == ST_EXEC);

  // BNER0 compares R[rs] (low field) against r0; ADD reads rs/rt.
  assign ra_sel = (op == OP_BNER0) ? ir_q[BRS_HI:BRS_LO] : ir_q[RS_HI:RS_LO];
  assign rb_sel = (op == OP_BNER0) ? '0 : ir_q[RT_HI:RT_LO];

  assign branch_taken = (op == OP_BNER0) && (ra_data != rb_data);
  assign self_loop    = (HALT_ON_SELF_LOOP != 0) && branch_taken && (target == pc_q);
  assign pc_next      = branch_taken ? target : pc_q + 1'b1;

  assign we      = exec && ((op == OP_ADD) || (op == OP_LI));
  assign wr_data = (op == OP_LI) ? {{(DATA_W-4){1'b0}}, ir_q[IMM_HI:IMM_LO]}
                                 : ra_data + rb_data;

  register_file u_register_file (
    .clk      (clk),
    .reset    (reset),
    .ra_sel   (ra_sel),
    .rb_sel   (rb_sel),
    .dbg_sel  (dbg_sel),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .dbg_data (dbg_data),
    .we       (we),
    .wr_sel   (ir_q[RD_HI:RD_LO]),
    .wr_data  (wr_data)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; combinational blocks below use blocking with defaults.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (run) state_d = ST_EXEC;
      ST_EXEC:  state_d = self_loop ? ST_HALT : ST_FETCH;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    halted = 1'b0;
    case (state_q)
      ST_EXEC: retire = 1'b1;
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      count_q <= '0;
    end else begin
      if (state_q == ST_FETCH && run) ir_q <= instruction;
      if (exec) begin
        pc_q <= pc_next;
        if (count_q != '1) count_q <= count_q + 1'b1;
      end
    end
  end

  assign pc           = pc_q;
  assign retire_count = count_q;

endmodule

// File: tb/tb_simple_cpu_core.sv
// Self-checking bench for simple_cpu_core: an instruction-level model tracks the
// architectural state each cycle, with directed scenarios pinning literal results.
module tb_simple_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] pc;
  logic [7:0] instruction;
  logic       retire;
  logic [7:0] retire_count;
  logic       halted;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  logic [7:0] imem [16];
  assign instruction = imem[pc];

  simple_cpu_core dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc           (pc),
    .instruction  (instruction),
    .retire       (retire),
    .retire_count (retire_count),
    .halted       (halted),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: an instruction is fetched on one edge and its
  // architectural effect lands on the following edge.
  int m_r [4];
  int m_pc, m_cnt, m_ir;
  bit m_busy, m_halted;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_pc = 0; m_cnt = 0; m_ir = 0; m_busy = 0; m_halted = 0;
    end else if (m_busy) begin
      int op, a, b, c, tgt;
      op  = (m_ir >> 6) & 3;
      a   = (m_ir >> 4) & 3;
      b   = (m_ir >> 2) & 3;
      c   = m_ir & 3;
      tgt = (m_ir >> 2) & 15;
      if (op == 0) begin
        m_r[a] = (m_r[b] + m_r[c]) % 256;
        m_pc = (m_pc + 1) % 16;
      end else if (op == 1) begin
        m_pc = (m_pc + 1) % 16;
      end else if (op == 2) begin
        m_r[a] = m_ir & 15;
        m_pc = (m_pc + 1) % 16;
      end else begin
        if (m_r[c] != m_r[0]) begin
          if (tgt == m_pc) m_halted = 1;
          m_pc = tgt;
        end else begin
          m_pc = (m_pc + 1) % 16;
        end
      end
      if (m_cnt < 255) m_cnt++;
      m_busy = 0;
    end else if (!m_halted && run) begin
      m_ir = imem[m_pc];
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, m_pc);
      check("retire", retire, m_busy);
      check("halted", halted, m_halted);
      check("retire_count", retire_count, m_cnt);
      check("dbg_data", dbg_data, m_r[dbg_sel]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_std();
    for (int i = 0; i < 16; i++) imem[i] = 8'h40;
    imem[0] = 8'h8A; imem[1] = 8'h90; imem[2] = 8'hA0; imem[3] = 8'hB1;
    imem[4] = 8'h17; imem[5] = 8'h29; imem[6] = 8'hD1; imem[7] = 8'hDF;
  endtask

  task automatic read_reg(input string name, input logic [1:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic run_to_halt(input string name, input int exp_cycles);
    int cyc;
    cyc = 0;
    while (!halted && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check(name, cyc, exp_cycles);
  endtask

  initial begin
    load_std();
    do_reset();
    chk_en = 1'b1;

    // Reset state.
    check("reset_pc", pc, 0);
    check("reset_count", retire_count, 0);
    check("reset_halted", halted, 0);
    check("reset_retire", retire, 0);
    for (int i = 0; i < 4; i++) read_reg("reset_reg", 2'(i), 8'h00);

    // Standard program straight through.
    run = 1'b1;
    run_to_halt("std_cycles", 70);
    read_reg("std_r2", 2'd2, 8'h37);
    read_reg("std_r1", 2'd1, 8'h0A);
    check("std_count", retire_count, 35);
    check("std_pc", pc, 7);
    tick(6);
    check("halt_count", retire_count, 35);
    check("halt_flag", halted, 1);

    // Doubling with rd == rs == rt.
    for (int i = 0; i < 16; i++) imem[i] = 8'h15;
    imem[0] = 8'h9F;
    do_reset();
    run = 1'b1;
    tick(4);
    read_reg("dbl_30", 2'd1, 8'd30);
    tick(8);
    read_reg("dbl_wrap", 2'd1, 8'hE0);

    // run held low for 5 cycles at an instruction boundary.
    load_std();
    do_reset();
    run = 1'b1;
    tick(10);
    run = 1'b0;
    tick(5);
    check("frz_pc", pc, 5);
    check("frz_count", retire_count, 5);
    check("frz_retire", retire, 0);
    run = 1'b1;
    run_to_halt("frz_resume_cycles", 60);
    read_reg("frz_r2", 2'd2, 8'h37);
    check("frz_total", retire_count, 35);

    // run dropped during EXEC.
    do_reset();
    run = 1'b1;
    tick(1);
    run = 1'b0;
    check("drop_retire", retire, 1);
    tick(1);
    check("drop_count", retire_count, 1);
    check("drop_pc", pc, 1);
    read_reg("drop_r0", 2'd0, 8'd10);
    tick(3);
    check("drop_wait_count", retire_count, 1);
    check("drop_wait_pc", pc, 1);
    run = 1'b1;
    tick(2);
    check("drop_next_count", retire_count, 2);

    // Reset during EXEC of an ADD.
    for (int i = 0; i < 16; i++) imem[i] = 8'h40;
    imem[0] = 8'h95; imem[1] = 8'h25;
    do_reset();
    run = 1'b1;
    tick(3);
    read_reg("rst_pre_r1", 2'd1, 8'd5);
    check("rst_in_exec", retire, 1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    run = 1'b0;
    check("rst_pc", pc, 0);
    check("rst_count", retire_count, 0);
    check("rst_retire", retire, 0);
    read_reg("rst_r2", 2'd2, 8'h00);
    read_reg("rst_r1", 2'd1, 8'h00);

    // NOPs everywhere: pc wrap and count saturation.
    for (int i = 0; i < 16; i++) imem[i] = 8'h40;
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(2);
      check("wrap_pc", pc, (i + 1) % 16);
    end
    tick(2 * 250);
    check("sat_count", retire_count, 255);
    tick(4);
    check("sat_hold", retire_count, 255);

    // Randomized programs, run and debug select, with occasional reset.
    for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) == 0) begin
        for (int i = 0; i < 16; i++) imem[i] = 8'($urandom);
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      run = ($urandom_range(0, 3) != 0);
      dbg_sel = 2'($urandom_range(0, 3));
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_cpu_core.md
SIMPLE_CPU_CORE -- requirements
Module: simple_cpu_core

Interface
REQ-001 Parameter HALT_ON_SELF_LOOP, default 1: when 1, a taken BNER0 whose target equals its own address halts the core.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  when high, permits the core to start the next fetch.
REQ-005 pc  output  4  instruction address driven to the instruction memory.
REQ-006 instruction  input  8  combinational instruction-memory data for the current pc.
REQ-007 retire  output  1  one-cycle pulse when an instruction completes.
REQ-008 retire_count  output  8  number of retired instructions, saturating.
REQ-009 halted  output  1  high while the core is in HALT.
REQ-010 dbg_sel  input  2  debug register select.
REQ-011 dbg_data  output  8  combinational contents of register dbg_sel.

Function
REQ-012 The instruction encoding SHALL be: [7:6] opcode; 00=ADD, 01=NOP, 10=LI, 11=BNER0.
REQ-013 ADD rd=[5:4], rs=[3:2], rt=[1:0] SHALL perform R[rd] = (R[rs] + R[rt]) mod 256 and pc = pc+1.
REQ-014 LI rd=[5:4], imm=[3:0] SHALL perform R[rd] = zero-extended imm and pc = pc+1.
REQ-015 BNER0 target=[5:2], rs=[1:0] SHALL set pc = target if R[rs] != R[0], else pc = pc+1.
REQ-016 NOP (opcode 01) SHALL change no register, set pc = pc+1, and retire.
REQ-017 pc+1 SHALL wrap from 15 to 0.
REQ-018 There SHALL be four 8-bit general registers r0..r3; r0 is writable like any other register.
REQ-019 FSM states SHALL be FETCH, EXEC and HALT.
REQ-020 In FETCH with run=1, the core SHALL latch instruction into the IR and go to EXEC; with run=0 it SHALL stay in FETCH with no state change.
REQ-021 In EXEC, the core SHALL perform the REQ-013..016 update and pulse retire, then:
- go to HALT if the self-loop condition of REQ-001 holds (pc unchanged);
- otherwise go to FETCH.
REQ-022 Each instruction SHALL take exactly 2 cycles (FETCH + EXEC) when run=1.
REQ-023 Deassertion of run during EXEC SHALL NOT abort it; the instruction completes and retires.
REQ-024 Register reads SHALL return pre-write values, so rd == rs/rt uses old operands.
REQ-025 retire_count SHALL increment on each retire and saturate at 255.
REQ-026 HALT SHALL be terminal until reset:
- no retire, no register or pc change;
- halted=1.
REQ-027 dbg_data SHALL be combinational and reflect a write on the cycle after the write edge.

Reset
REQ-028 reset=1 SHALL, at the clock edge, regardless of state (including mid-EXEC):
- set state=FETCH, pc=0, IR=0, r0..r3=0, retire_count=0;
- clear retire and halted;
- suppress any write from the EXEC instruction in progress.
REQ-029 The first fetch SHALL occur on the first edge with reset=0 and run=1.

Structure
REQ-030 Package cpu_pkg SHALL hold:
- the opcode enum and the FSM state enum;
- instruction field bit-position constants;
- widths: DATA_W=8, PC_W=4, REG_SEL_W=2.
REQ-031 A sub-module register_file SHALL be used:
- 4x8 storage with two combinational read ports plus a debug read port;
- one synchronous write port with synchronous reset clear.
REQ-032 The core SHALL instantiate instruction_memory externally; it SHALL NOT embed program storage.

Verification
REQ-033 Bench SHALL cover:
- Standard 8-instruction program (li r0,10; li r1,0; li r2,0; li r3,1; add r1,r1,r3; add r2,r2,r1; bner0 r1,4; bner0 r3,7), run=1 -> halted after 70 cycles, r2=0x37, r1=0x0A, retire_count=35.
- LI then ADD with rd=rs: li r1,15; add r1,r1,r1 -> r1=30; repeated doubling wraps mod 256.
- run held low for 5 cycles mid-program -> pc and registers frozen, no retire; resumes identically.
- run dropped during EXEC -> that instruction retires; the next fetch waits for run.
- reset asserted in EXEC of an ADD -> destination unwritten, all state zero next cycle.
- pc wrap: NOPs at 0..15 -> pc sequence 0..15,0, retire_count saturates at 255.
